// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array operand feeder: lane count,
// FSM encoding and the lane <-> byte mapping used on 32-bit words.
package systolic_feeder_pkg;

    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_DRAIN
    } state_e;

    // Lane 0 occupies the most significant byte.
    function automatic int unsigned lane_lsb(input int unsigned r);
        return (LANES - 1 - r) * 8;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input int unsigned r);
        return word[lane_lsb(r) +: 8];
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Feeder bundle: job control, A/B buffer read ports and array operand outputs.
interface systolic_feeder_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned K_W    = 16
);
    logic              start;
    logic [K_W-1:0]    k_len;
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] b_base;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [31:0]       a_data;
    logic [31:0]       b_data;
    logic [31:0]       in_left;
    logic [31:0]       in_up;
    logic              pe_clear;
    logic              busy;
    logic              done;

    modport master (
        input  start, k_len, a_base, b_base, a_data, b_data,
        output a_addr, b_addr, in_left, in_up, pe_clear, busy, done
    );

    modport slave (
        output start, k_len, a_base, b_base, a_data, b_data,
        input  a_addr, b_addr, in_left, in_up, pe_clear, busy, done
    );
endinterface

// File: rtl/systolic_feeder_skew_line.sv
// One 8-bit operand lane: DEPTH-cycle delay of data plus its valid bit,
// followed by a registered output that drives zero when the lane is invalid.
module systolic_feeder_skew_line #(
    parameter int unsigned DEPTH = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din_i,
    input  logic       vld_i,
    output logic [7:0] dout_o
);
    logic [7:0] tail_dat;
    logic       tail_vld;
    logic [7:0] dout_q;

    if (DEPTH == 0) begin : g_direct
        assign tail_dat = din_i;
        assign tail_vld = vld_i;
    end else begin : g_pipe
        logic [7:0]       dat_q [DEPTH];
        logic [DEPTH-1:0] vld_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int unsigned i = 0; i < DEPTH; i++) dat_q[i] <= '0;
                vld_q <= '0;
            end else begin
                dat_q[0] <= din_i;
                vld_q[0] <= vld_i;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    dat_q[i] <= dat_q[i-1];
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end

        assign tail_dat = dat_q[DEPTH-1];
        assign tail_vld = vld_q[DEPTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dout_q <= '0;
        else     dout_q <= tail_vld ? tail_dat : '0;
    end

    assign dout_o = dout_q;
endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for the 4x4 int8 systolic array: fetches K word pairs,
// skews lane r by r cycles, clears the accumulators first and signals done.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned K_W         = 16,
    parameter int unsigned DRAIN_EXTRA = 7
) (
    input logic              clk,
    input logic              rst,
    systolic_feeder_if.master bus
);
    // Last DRAIN count: covers the 3-cycle skew plus read latency plus array propagation.
    localparam logic [K_W-1:0] DRAIN_LAST = K_W'(4 + DRAIN_EXTRA);

    state_e            state_q;
    logic [K_W-1:0]    k_q;
    logic [K_W-1:0]    cnt_q;
    logic [ADDR_W-1:0] a_base_q, b_base_q;
    logic [ADDR_W-1:0] a_addr_q, b_addr_q;
    logic              pe_clear_q, busy_q, done_q;
    logic              rd_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            cnt_q      <= '0;
            a_base_q   <= '0;
            b_base_q   <= '0;
            a_addr_q   <= '0;
            b_addr_q   <= '0;
            pe_clear_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_vld_q   <= 1'b0;
        end else begin
            pe_clear_q <= 1'b0;
            done_q     <= 1'b0;
            rd_vld_q   <= (state_q == ST_FETCH);
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.k_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            k_q        <= bus.k_len;
                            a_base_q   <= bus.a_base;
                            b_base_q   <= bus.b_base;
                            pe_clear_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    a_addr_q <= a_base_q;
                    b_addr_q <= b_base_q;
                    cnt_q    <= K_W'(1);
                    state_q  <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (cnt_q == k_q) begin
                        a_addr_q <= '0;
                        b_addr_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= ST_DRAIN;
                    end else begin
                        a_addr_q <= a_addr_q + ADDR_W'(1);
                        b_addr_q <= b_addr_q + ADDR_W'(1);
                        cnt_q    <= cnt_q + K_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + K_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    logic [7:0]  left_lane [LANES];
    logic [7:0]  up_lane   [LANES];
    logic [31:0] left_word, up_word;

    for (genvar r = 0; r < LANES; r++) begin : g_lane
        systolic_feeder_skew_line #(.DEPTH(r)) u_a (
            .clk    (clk),
            .rst    (rst),
            .din_i  (lane_byte(bus.a_data, r)),
            .vld_i  (rd_vld_q),
            .dout_o (left_lane[r])
        );
        systolic_feeder_skew_line #(.DEPTH(r)) u_b (
            .clk    (clk),
            .rst    (rst),
            .din_i  (lane_byte(bus.b_data, r)),
            .vld_i  (rd_vld_q),
            .dout_o (up_lane[r])
        );
    end

    always_comb begin
        left_word = '0;
        up_word   = '0;
        for (int unsigned r = 0; r < LANES; r++) begin
            left_word[lane_lsb(r) +: 8] = left_lane[r];
            up_word[lane_lsb(r) +: 8]   = up_lane[r];
        end
    end

    assign bus.a_addr   = a_addr_q;
    assign bus.b_addr   = b_addr_q;
    assign bus.in_left  = left_word;
    assign bus.in_up    = up_word;
    assign bus.pe_clear = pe_clear_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: vector table for the single-word job,
// reference-stream and array-model checks for the multi-cycle scenarios.
module tb_systolic_feeder;
    localparam int DE = 7;
    localparam int NT = 48;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_feeder_if #(.ADDR_W(14), .K_W(16)) bus ();
    systolic_feeder_if #(.ADDR_W(4),  .K_W(16)) bus_w ();

    systolic_feeder #(.ADDR_W(14), .K_W(16), .DRAIN_EXTRA(DE)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    systolic_feeder #(.ADDR_W(4), .K_W(16), .DRAIN_EXTRA(DE)) dut_w (
        .clk (clk), .rst (rst), .bus (bus_w)
    );

    logic [31:0] a_mem [64];
    logic [31:0] b_mem [64];

    always @(posedge clk) begin
        bus.a_data <= a_mem[bus.a_addr[5:0]];
        bus.b_data <= b_mem[bus.b_addr[5:0]];
    end
    assign bus_w.a_data = 32'hFFFF_FFFF;
    assign bus_w.b_data = 32'hFFFF_FFFF;

    logic [31:0] tr_left [NT];
    logic [31:0] tr_up   [NT];
    logic [13:0] tr_aa   [NT];
    logic [13:0] tr_ba   [NT];
    logic        tr_clr  [NT];
    logic        tr_busy [NT];
    logic        tr_done [NT];

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
    endtask

    // Expected array-side stream: lane r carries byte r of word n at cycle 4+n+r.
    function automatic logic [31:0] ref_stream(input bit is_a, input int k, input int base, input int t);
        logic [31:0] res = '0;
        logic [31:0] w;
        for (int r = 0; r < 4; r++) begin
            int n = t - 4 - r;
            if (n >= 0 && n < k) begin
                w = is_a ? a_mem[(base + n) % 64] : b_mem[(base + n) % 64];
                res[(3 - r) * 8 +: 8] = w[(3 - r) * 8 +: 8];
            end
        end
        return res;
    endfunction

    task automatic run_job(input int k, input int ab, input int bb, input int hold_until, input int mid_t);
        @(negedge clk);
        bus.start = 1'b1; bus.k_len = 16'(k); bus.a_base = 14'(ab); bus.b_base = 14'(bb);
        for (int t = 1; t < NT; t++) begin
            @(negedge clk);
            tr_left[t] = bus.in_left;  tr_up[t]   = bus.in_up;
            tr_aa[t]   = bus.a_addr;   tr_ba[t]   = bus.b_addr;
            tr_clr[t]  = bus.pe_clear; tr_busy[t] = bus.busy; tr_done[t] = bus.done;
            if (t == mid_t) begin
                bus.start = 1'b1; bus.k_len = 16'd9; bus.a_base = 14'd100; bus.b_base = 14'd100;
            end else if (t >= hold_until) begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
    endtask

    typedef struct {
        int          t;
        logic [31:0] left;
        logic [31:0] up;
        logic [2:0]  ctl;   // {pe_clear, busy, done}
    } vec_t;

    vec_t tbl [16];
    int   acc;
    int   cnt;
    int   first;
    logic [3:0] wa [20];
    logic [3:0] wb [20];
    logic       wd [20];

    initial begin
        for (int i = 0; i < 64; i++) begin
            a_mem[i] = {8'(i + 1), 8'(i + 65), 8'(i + 129), 8'(i + 193)};
            b_mem[i] = {8'(i + 33), 8'(i + 97), 8'(i + 161), 8'(i + 225)};
        end
        bus.start = 1'b0; bus.k_len = '0; bus.a_base = '0; bus.b_base = '0;
        bus_w.start = 1'b0; bus_w.k_len = '0; bus_w.a_base = '0; bus_w.b_base = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", 0, {bus.in_left ^ bus.in_up, 14'(bus.a_addr | bus.b_addr),
                               bus.pe_clear, bus.busy, bus.done}, '0);
        rst = 1'b0;

        // Single-word job.
        a_mem[0] = 32'h0102_0304;
        b_mem[0] = 32'h0506_0708;
        for (int i = 0; i < 16; i++) tbl[i] = '{t: i + 1, left: '0, up: '0, ctl: {1'b0, (i + 1 <= 14), 1'b0}};
        tbl[0].ctl  = 3'b110;
        tbl[3].left = 32'h0100_0000; tbl[3].up = 32'h0500_0000;
        tbl[4].left = 32'h0002_0000; tbl[4].up = 32'h0006_0000;
        tbl[5].left = 32'h0000_0300; tbl[5].up = 32'h0000_0700;
        tbl[6].left = 32'h0000_0004; tbl[6].up = 32'h0000_0008;
        tbl[14].ctl = 3'b001;
        run_job(1, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) begin
            chk("basic_left", tbl[i].t, tr_left[tbl[i].t], tbl[i].left);
            chk("basic_up",   tbl[i].t, tr_up[tbl[i].t],   tbl[i].up);
            chk("basic_ctl",  tbl[i].t, {29'd0, tr_clr[tbl[i].t], tr_busy[tbl[i].t], tr_done[tbl[i].t]},
                {29'd0, tbl[i].ctl});
        end

        // Identity A, ones B: skew windows and array result.
        a_mem[0] = 32'h0100_0000; a_mem[1] = 32'h0001_0000;
        a_mem[2] = 32'h0000_0100; a_mem[3] = 32'h0000_0001;
        for (int i = 0; i < 4; i++) b_mem[i] = 32'h0101_0101;
        run_job(4, 0, 0, 1, 0);
        for (int t = 1; t < 26; t++) begin
            chk("skew_left", t, tr_left[t], ref_stream(1'b1, 4, 0, t));
            chk("skew_up",   t, tr_up[t],   ref_stream(1'b0, 4, 0, t));
        end
        for (int r = 0; r < 4; r++) begin
            cnt = 0; first = -1;
            for (int t = 1; t < NT; t++)
                if (tr_up[t][(3 - r) * 8 +: 8] != 8'h00) begin
                    cnt++;
                    if (first < 0) first = t;
                end
            chk("skew_up_count", r, 32'(cnt), 32'd4);
            chk("skew_up_first", r, 32'(first), 32'(4 + r));
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int tt = 1; tt < NT; tt++)
                    if (tt - j >= 1 && tt - i >= 1)
                        acc += int'($signed(tr_left[tt - j][(3 - i) * 8 +: 8])) *
                               int'($signed(tr_up[tt - i][(3 - j) * 8 +: 8]));
                chk("array_c", i * 4 + j, 32'(acc), 32'(1));
            end
        chk("skew_done", 18, 32'(tr_done[18]), 32'd1);

        // Second start mid-FETCH must be ignored.
        run_job(4, 20, 30, 1, 3);
        for (int t = 1; t < 8; t++) begin
            chk("midstart_a_addr", t, 32'(tr_aa[t]), (t >= 2 && t <= 5) ? 32'(20 + t - 2) : 32'd0);
            chk("midstart_b_addr", t, 32'(tr_ba[t]), (t >= 2 && t <= 5) ? 32'(30 + t - 2) : 32'd0);
        end
        for (int t = 1; t < NT; t++) begin
            chk("midstart_done", t, 32'(tr_done[t]), 32'(t == 18));
            chk("midstart_left", t, tr_left[t], ref_stream(1'b1, 4, 20, t));
        end

        // Zero-length job.
        run_job(0, 5, 5, 1, 0);
        chk("k0_done_c1", 1, 32'(tr_done[1]), 32'd1);
        cnt = 0;
        for (int t = 1; t < NT; t++) cnt += int'(tr_clr[t]) + int'(tr_busy[t]) + int'(tr_done[t]);
        chk("k0_no_activity", 0, 32'(cnt), 32'd1);

        // Reset during the third fetch of a K=8 job.
        @(negedge clk);
        bus.start = 1'b1; bus.k_len = 16'd8; bus.a_base = 14'd20; bus.b_base = 14'd30;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pre_addr", 4, 32'(bus.a_addr), 32'd22);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", 4, {bus.in_left | bus.in_up, 14'(bus.a_addr | bus.b_addr),
                                   bus.pe_clear, bus.busy, bus.done}, '0);
        @(negedge clk);
        rst = 1'b0;
        run_job(2, 40, 44, 1, 0);
        for (int t = 1; t < NT; t++) begin
            chk("post_rst_left", t, tr_left[t], ref_stream(1'b1, 2, 40, t));
            chk("post_rst_up",   t, tr_up[t],   ref_stream(1'b0, 2, 44, t));
        end
        chk("post_rst_done", 16, 32'(tr_done[16]), 32'd1);

        // Back-to-back jobs with start held high.
        run_job(5, 20, 30, 20, 0);
        chk("b2b_done1",  19, 32'(tr_done[19]), 32'd1);
        chk("b2b_clear2", 20, 32'(tr_clr[20]),  32'd1);
        chk("b2b_done2",  38, 32'(tr_done[38]), 32'd1);
        for (int t = 1; t < NT; t++) begin
            chk("b2b_left", t, tr_left[t], ref_stream(1'b1, 5, 20, t) | ref_stream(1'b1, 5, 20, t - 19));
            chk("b2b_up",   t, tr_up[t],   ref_stream(1'b0, 5, 30, t) | ref_stream(1'b0, 5, 30, t - 19));
        end

        // Address wrap on the 4-bit instance.
        @(negedge clk);
        bus_w.start = 1'b1; bus_w.k_len = 16'd3; bus_w.a_base = 4'hE; bus_w.b_base = 4'h3;
        for (int t = 1; t < 20; t++) begin
            @(negedge clk);
            wa[t] = bus_w.a_addr; wb[t] = bus_w.b_addr; wd[t] = bus_w.done;
            bus_w.start = 1'b0;
        end
        chk("wrap_a1", 1, 32'(wa[1]), 32'h0);
        chk("wrap_a2", 2, 32'(wa[2]), 32'hE);
        chk("wrap_a3", 3, 32'(wa[3]), 32'hF);
        chk("wrap_a4", 4, 32'(wa[4]), 32'h0);
        chk("wrap_b4", 4, 32'(wb[4]), 32'h5);
        chk("wrap_a5", 5, 32'(wa[5]), 32'h0);
        chk("wrap_done16", 16, 32'(wd[16]), 32'd0);
        chk("wrap_done17", 17, 32'(wd[17]), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
